tx_byte_fetch: RTL
==================

TX_BYTE_FETCH -- requirements
Module: tx_byte_fetch

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 16, the width of the packet byte-length input and the internal byte counter.
REQ-002 SHALL have parameter C_S_AXIS_TDATA_WIDTH, default 64, the FIFO word width; only 64 is supported.
REQ-003 SHALL have parameter UNDERRUN_TIMEOUT, default 255, the FIFO-empty wait limit in cycles; used only with the macro in REQ-027.
REQ-004 S_AXIS_ACLK  in  1  single clock; all logic rising-edge.
REQ-005 S_AXIS_ARESETN  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse that begins a packet.
REQ-007 pkt_len_byte  in  LEN_WIDTH  bytes to emit; sampled on the start cycle.
REQ-008 DATA_TO_ACC  in  64  FWFT queue head word; valid whenever EMPTYN_TO_ACC=1.
REQ-009 EMPTYN_TO_ACC  in  1  queue non-empty.
REQ-010 ACC_ASK_DATA  out  1  one-cycle read strobe that pops the queue head.
REQ-011 byte_out  out  8  current byte.
REQ-012 byte_valid  out  1  byte_out is valid.
REQ-013 byte_ready  in  1  downstream accepts byte_out.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at packet end.
REQ-016 underrun  out  1  packet aborted on FIFO-empty timeout; sticky until the next accepted start.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, SHIFT and DONE; transitions:
- IDLE->LOAD on start with pkt_len_byte!=0.
- IDLE->DONE on start with pkt_len_byte==0.
- LOAD->SHIFT on the cycle EMPTYN_TO_ACC=1.
- SHIFT->LOAD or SHIFT->DONE per REQ-021.
- DONE->IDLE unconditionally.
REQ-018 start outside IDLE SHALL be ignored; pkt_len_byte SHALL be latched only on an accepted start.
REQ-019 In LOAD with EMPTYN_TO_ACC=1, the block SHALL, in that same cycle:
- assert ACC_ASK_DATA for exactly one cycle;
- capture DATA_TO_ACC into a 64-bit shift register;
- set the byte index to 0.
With EMPTYN_TO_ACC=0 it SHALL hold LOAD with ACC_ASK_DATA=0.
REQ-020 In SHIFT:
- byte_valid SHALL be 1 and byte_out SHALL be shift register bits [8*i+7:8*i] (byte 0 = bits 7:0, LSB first).
- byte_out SHALL stay stable while byte_valid=1 and byte_ready=0.
REQ-021 On each byte_valid&byte_ready handshake:
- the remaining-byte counter SHALL decrement and the index SHALL increment.
- If the counter reaches 0, the next state SHALL be DONE.
- Otherwise, if the index was 7, the next state SHALL be LOAD.
- Otherwise the FSM SHALL stay in SHIFT.
REQ-022 When pkt_len_byte is not a multiple of 8, unused bytes of the last word SHALL be discarded; that word is still popped exactly once.
REQ-023 Total ACC_ASK_DATA pulses per packet SHALL equal ceil(pkt_len_byte/8).
REQ-024 Latency:
- start at cycle 0 with FIFO non-empty gives LOAD+ASK at cycle 1 and first byte_valid at cycle 2.
- each word boundary costs exactly one LOAD cycle with byte_valid=0.
REQ-025 done SHALL be high for the single DONE cycle; busy SHALL drop in the following cycle.

Reset
REQ-026 Assertion of S_AXIS_ARESETN=0 at any time, including mid-packet, SHALL immediately force:
- IDLE state;
- ACC_ASK_DATA=0, byte_valid=0, byte_out=0, busy=0, done=0, underrun=0;
- counters and the shift register to 0.
No FIFO pop SHALL occur while reset is asserted.

Configuration
REQ-027 Macro TX_BYTE_FETCH_UNDERRUN_EN.
- When defined: a wait counter SHALL count consecutive LOAD cycles with EMPTYN_TO_ACC=0. On reaching UNDERRUN_TIMEOUT, the FSM SHALL go to DONE, set underrun=1 and pop nothing further.
- When undefined: LOAD SHALL wait indefinitely, underrun SHALL be tied 0, and no wait counter SHALL exist.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- pkt_len_byte=16, FIFO words 0x0706050403020100 and 0x0F0E0D0C0B0A0908, byte_ready=1 -> bytes 0x00..0x0F in order, 2 ASK pulses, done at the cycle after the 16th handshake.
- pkt_len_byte=5, one word -> bytes 0x00..0x04, 1 ASK pulse, bytes 5..7 never presented.
- pkt_len_byte=0 -> done 1 cycle after start, no ASK, no byte_valid.
- byte_ready toggling 1,0,0,1 -> byte_out held stable during stall cycles; no byte skipped or duplicated.
- FIFO empty for 300 cycles after start, macro defined, UNDERRUN_TIMEOUT=255 -> done and underrun=1 after 255 LOAD wait cycles, 0 ASK pulses; with macro undefined -> remains busy and outputs first byte once a word arrives.
- Reset asserted during the 3rd byte of a 16-byte packet -> all outputs 0 immediately; the next start with 8 bytes delivers a fresh word correctly.

Source files
------------

// File: rtl/tx_byte_fetch_if.sv
// Byte-fetch bus: FWFT word queue on one side, byte stream on the other.
// master = tx_byte_fetch, slave = queue/consumer environment.
interface tx_byte_fetch_if;
  // Queue: DATA_TO_ACC is valid while EMPTYN_TO_ACC=1; a one-cycle ACC_ASK_DATA pops it.
  // Bytes: byte_out transfers on a cycle with byte_valid=1 and byte_ready=1. Once
  // byte_valid is raised, it and byte_out hold until that transfer happens.
  logic [63:0] DATA_TO_ACC;
  logic        EMPTYN_TO_ACC;
  logic        ACC_ASK_DATA;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;

  modport master (
    input  DATA_TO_ACC, EMPTYN_TO_ACC, byte_ready,
    output ACC_ASK_DATA, byte_out, byte_valid
  );

  modport slave (
    output DATA_TO_ACC, EMPTYN_TO_ACC, byte_ready,
    input  ACC_ASK_DATA, byte_out, byte_valid
  );
endinterface

// File: rtl/tx_byte_fetch.sv
// Pops 64-bit words from a FWFT queue and emits pkt_len_byte bytes, LSB first.
// Optional FIFO-empty timeout: define TX_BYTE_FETCH_UNDERRUN_EN.
module tx_byte_fetch #(
  parameter int LEN_WIDTH            = 16,
  parameter int C_S_AXIS_TDATA_WIDTH = 64,
  parameter int UNDERRUN_TIMEOUT     = 255
) (
  input  logic                 S_AXIS_ACLK,
  input  logic                 S_AXIS_ARESETN,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] pkt_len_byte,
  tx_byte_fetch_if.master      axis,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                          state, state_nxt;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] shreg;
  logic [LEN_WIDTH-1:0]            remain;
  logic [2:0]                      idx;
  logic                            hs;
  logic                            word_take;
  logic                            accept_start;
  logic                            timeout;

  assign accept_start = (state == IDLE) && start;
  assign word_take    = (state == LOAD) && axis.EMPTYN_TO_ACC;
  assign hs           = axis.byte_valid && axis.byte_ready;

`ifdef TX_BYTE_FETCH_UNDERRUN_EN
  localparam int WAIT_W = $clog2(UNDERRUN_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;

  // Counts consecutive empty LOAD cycles; the last one of the budget fires timeout.
  assign timeout = (state == LOAD) && !axis.EMPTYN_TO_ACC &&
                   (wait_cnt == WAIT_W'(UNDERRUN_TIMEOUT - 1));

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      wait_cnt <= '0;
      underrun <= 1'b0;
    end else begin
      if ((state == LOAD) && !axis.EMPTYN_TO_ACC) wait_cnt <= wait_cnt + 1'b1;
      else                                        wait_cnt <= '0;
      if (accept_start) underrun <= 1'b0;
      else if (timeout) underrun <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cfg = UNDERRUN_TIMEOUT;
  assign timeout  = 1'b0;
  assign underrun = 1'b0;
`endif

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (pkt_len_byte == '0) ? DONE : LOAD;
      LOAD: begin
        if (axis.EMPTYN_TO_ACC) state_nxt = SHIFT;
        else if (timeout)       state_nxt = DONE;
      end
      SHIFT: begin
        if (hs) begin
          if (remain == LEN_WIDTH'(1)) state_nxt = DONE;
          else if (idx == 3'd7)        state_nxt = LOAD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      remain <= '0;
      shreg  <= '0;
      idx    <= '0;
    end else begin
      if (accept_start) remain <= pkt_len_byte;
      else if (hs)      remain <= remain - 1'b1;
      // A fresh word always restarts at byte 0; leftover bytes of a short tail are dropped.
      if (word_take) begin
        shreg <= axis.DATA_TO_ACC;
        idx   <= '0;
      end else if (hs) begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign axis.ACC_ASK_DATA = word_take;
  assign axis.byte_valid   = (state == SHIFT);
  assign axis.byte_out     = shreg[{idx, 3'b000} +: 8];
  assign busy              = (state != IDLE);
  assign done              = (state == DONE);
  assign state_dbg         = state;

endmodule
